// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = (a - b) mod 2^WIDTH, one bit per clock, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERSUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERSUB_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bi;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_complete;

  // Full-subtract cell: two half-subtractors chained through the borrow flop.
  assign w_x       = r_a[0];
  assign w_y       = r_b[0];
  assign w_d       = w_x ^ w_y ^ r_bi;
  assign w_bo      = (~w_x & w_y) | (~(w_x ^ w_y) & r_bi);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SERSUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_overflow;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bi     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_overflow <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_res <= '0;
      r_bi  <= 1'b0;
      r_cnt <= '0;
`ifdef SERSUB_OVERFLOW_EN
      r_a_msb <= i_a[WIDTH-1];
      r_b_msb <= i_b[WIDTH-1];
`endif
    end else if (r_state == S_SHIFT) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_nxt;
      r_bi  <= w_bo;
      r_cnt <= r_cnt + 1'b1;
      // Results are published only here, so partial sums never reach the outputs.
      if (w_complete) begin
        r_diff   <= w_res_nxt;
        r_borrow <= w_bo;
`ifdef SERSUB_OVERFLOW_EN
        r_overflow <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_res_nxt[WIDTH-1]);
`endif
      end
    end
  end

  assign o_busy   = (r_state == S_SHIFT);
  assign o_done   = (r_state == S_DONE);
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;
`ifdef SERSUB_OVERFLOW_EN
  assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences, random ops vs arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_diff   (diff),
    .o_borrow (borrow)
`ifdef SERSUB_OVERFLOW_EN
    ,
    .o_overflow (ovf)
`endif
  );

`ifndef SERSUB_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] vdiff;
    logic       vborrow;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on the operands.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] md, output logic mbr, output logic mov);
    int s;
    md  = ma - mb;
    mbr = (ma < mb);
    s   = int'($signed(ma)) - int'($signed(mb));
    mov = (s < -128) || (s > 127);
  endtask

  // Issues one start pulse and waits (bounded) for done; leaves the bench at the done negedge.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob,
                        output logic [7:0] d, output logic br, output logic ov,
                        output int busy_cnt, output bit seen);
    @(negedge clk);
    start = 1'b1; a = oa; b = ob;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; seen = 1'b0; d = '0; br = 1'b0; ov = 1'b0;
    for (int k = 0; k < WIDTH + 6 && !seen; k++) begin
      if (done) begin
        seen = 1'b1; d = diff; br = borrow; ov = ovf;
      end else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  vec_t vecs[6];
  logic [7:0] gd, ed;
  logic       gbr, gov, ebr, eov;
  int         bcnt;
  bit         seen;
  int         ndone;
  int         t_done[$];
  logic [7:0] d_done[$];
  logic       o_done_q[$];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[5] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow, 0);
    chk("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].va, vecs[i].vb, gd, gbr, gov, bcnt, seen);
      chk($sformatf("vec%0d_done_seen", i), seen, 1);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, WIDTH);
      chk($sformatf("vec%0d_busy_at_done", i), busy, 0);
      chk($sformatf("vec%0d_diff", i), gd, vecs[i].vdiff);
      chk($sformatf("vec%0d_borrow", i), gbr, vecs[i].vborrow);
      @(negedge clk);
      chk($sformatf("vec%0d_done_fall", i), done, 0);
    end

    // Busy protection: new operands and start during SHIFT must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h37; b = 8'h12;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; gd = '0; gbr = 1'b1;
    for (int k = 0; k < 3 * WIDTH; k++) begin
      if (done) begin ndone++; gd = diff; gbr = borrow; end
      @(negedge clk);
    end
    chk("busyprot_done_count", ndone, 1);
    chk("busyprot_diff", gd, 8'h25);
    chk("busyprot_borrow", gbr, 0);

    // Reset asserted during the 4th SHIFT cycle.
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    chk("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrst_no_activity", ndone, 0);

    // Back-to-back with start held high.
    start = 1'b1; a = 8'h80; b = 8'h01;
    @(negedge clk);
    a = 8'h10; b = 8'h01;
    for (int k = 0; k < 4 * WIDTH; k++) begin
      if (k == WIDTH + 1) start = 1'b0;
      if (done) begin t_done.push_back(k); d_done.push_back(diff); o_done_q.push_back(ovf); end
      @(negedge clk);
    end
    chk("b2b_done_count", t_done.size(), 2);
    if (t_done.size() == 2) begin
      chk("b2b_spacing", t_done[1] - t_done[0], WIDTH + 1);
      chk("b2b_diff0", d_done[0], 8'h7F);
      chk("b2b_diff1", d_done[1], 8'h0F);
`ifdef SERSUB_OVERFLOW_EN
      chk("b2b_ovf0", o_done_q[0], 1);
      chk("b2b_ovf1", o_done_q[1], 0);
`endif
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(ra, rb, ed, ebr, eov);
      run_op(ra, rb, gd, gbr, gov, bcnt, seen);
      chk($sformatf("rnd%0d_done_seen", i), seen, 1);
      chk($sformatf("rnd%0d_diff a=%0h b=%0h", i, ra, rb), gd, ed);
      chk($sformatf("rnd%0d_borrow", i), gbr, ebr);
`ifdef SERSUB_OVERFLOW_EN
      chk($sformatf("rnd%0d_ovf", i), gov, eov);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
